mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified memory port between the instruction-cache fill FSM, the data-cache fill FSM and the data-cache write-through path.
- Grants the port to one requester at a time and muxes address, enable and write data from that requester onto the memory.
- Routes the returned data and data-valid strobe only to the owner of the current transfer.
- A fill holds the port until its last word has returned; a write holds it for exactly one cycle.

Parameters:
BEATS, 8, number of mem_data_valid beats that complete one cache-line fill (1..15)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache fill request; held until i_grant
i_addr  in  ADDR_W  I-cache fill address, driven by the I fill FSM every cycle
d_req  in  1  D-cache fill request; held until d_grant
d_addr  in  ADDR_W  D-cache fill address, driven by the D fill FSM every cycle
d_wr_req  in  1  D-cache write-through request; held until d_wr_ack
d_wr_addr  in  ADDR_W  write address
d_wr_data  in  DATA_W  write data
mem_data_out  in  DATA_W  read data from memory
mem_data_valid  in  1  read data valid from memory
mem_enable  out  1  memory access enable
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
i_grant  out  1  I fill owns the port
d_grant  out  1  D fill owns the port
d_wr_ack  out  1  one-cycle pulse: write accepted this cycle
i_data_valid  out  1  mem_data_valid gated to the I owner
d_data_valid  out  1  mem_data_valid gated to the D owner
fill_data  out  DATA_W  mem_data_out, passed through to both caches
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, IFILL, DFILL, WRITE. The state register and a 4-bit beat counter update every clk.
- Outputs are decoded from the registered state:
  - i_grant = IFILL; d_grant = DFILL; d_wr_ack = WRITE.
  - The grant rises one cycle after the request is sampled in IDLE.
- Reset: state=IDLE, beat_cnt=0, last_fill=D (so the first contested fill goes to I). All outputs are 0 and mem_addr/mem_data_in are 0.
- IDLE: mem_enable=0, mem_wr=0, mem_addr=0. mem_data_valid is ignored and never forwarded. Next state is chosen by priority:
  1. d_wr_req -> WRITE.
  2. If both i_req and d_req: go to the fill not named by last_fill.
  3. Only i_req -> IFILL; only d_req -> DFILL.
  4. Otherwise stay in IDLE.
- IFILL / DFILL:
  - mem_enable=1, mem_wr=0; mem_addr = i_addr or d_addr respectively.
  - The owner's *_data_valid = mem_data_valid; the other side's is 0.
  - Each valid beat increments beat_cnt.
  - On the beat where beat_cnt==BEATS-1 and mem_data_valid=1: forward that beat, clear beat_cnt, set last_fill to this side, next state IDLE.
  - The fill is non-preemptible: d_wr_req and the other side's request wait.
  - Deassertion of the owner's req mid-fill is ignored; the arbiter releases only on beat count.
- WRITE: one cycle only. mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_ack=1. Next state is always IDLE.
- Back-to-back transfers: a request is re-arbitrated in the IDLE cycle after each transfer, so the minimum gap between transfers is one idle cycle. A write arriving with both misses pending is served first.
- mem_data_in = 0 outside WRITE.
- fill_data = mem_data_out in every state.
- Reset asserted mid-fill or mid-write forces IDLE on the next edge and discards the partial beat count. Stray valids after reset are not forwarded.

Test Plan:
1. Reset, then i_req=1 with i_addr=0x1000 and 8 valid beats spaced 4 cycles apart -> i_grant high from the cycle after the request until the cycle of the 8th valid. mem_addr tracks i_addr. i_data_valid pulses 8 times, d_data_valid never pulses. Back to IDLE next cycle.
2. i_req and d_req asserted in the same cycle after reset -> IFILL first. After 8 beats, one IDLE cycle, then DFILL. Repeat both requests -> IFILL again (round-robin alternation).
3. d_wr_req (addr 0x2002, data 0xBEEF) together with i_req and d_req -> WRITE for exactly one cycle with mem_wr=1, mem_addr=0x2002, mem_data_in=0xBEEF, d_wr_ack pulses once. Fills follow afterwards.
4. d_wr_req raised during the 3rd beat of a DFILL -> write waits until DFILL completes all 8 beats, then WRITE occurs after one IDLE cycle.
5. mem_data_valid pulsed in IDLE -> no *_data_valid output and beat_cnt stays 0. In the first cycle of IFILL with no valid -> beat_cnt unchanged.
6. rst asserted after 5 beats of an IFILL -> IDLE on the next edge with all outputs 0. A new i_req then requires a full 8 beats to release.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one unified memory port between the I-cache fill FSM,
//               the D-cache fill FSM and the D-cache write-through path.
//               A fill owns the port until its last beat returns. A write
//               owns it for exactly one cycle. Contested fills alternate
//               between the I side and the D side.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               i_req/i_addr             - I fill request and address
//               d_req/d_addr             - D fill request and address
//               d_wr_req/addr/data       - D write-through request
//               mem_data_out/valid       - memory read return
//               mem_enable/wr/addr/
//               mem_data_in              - memory request side
//               i_grant, d_grant,
//               d_wr_ack                 - ownership / write accept
//               i_data_valid,
//               d_data_valid             - return strobe routed to the owner
//               fill_data, busy          - read data pass-through, not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int BEATS  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              i_grant,
    output logic              d_grant,
    output logic              d_wr_ack,
    output logic              i_data_valid,
    output logic              d_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IFILL = 2'd1,
        ST_DFILL = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] C_LAST_BEAT = 4'(BEATS - 1);

    state_t     r_state_q;
    logic [3:0] r_beat_q;
    logic       r_last_d_q;   // 1: most recent completed fill was the D side

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_beat_q   <= 4'd0;
            r_last_d_q <= 1'b1;   // first contested fill goes to I
        end else begin
            case (r_state_q)
                ST_IDLE: begin
                    // Write-through first; it costs only one cycle.
                    if (d_wr_req) begin
                        r_state_q <= ST_WRITE;
                    end else if (i_req && d_req) begin
                        r_state_q <= r_last_d_q ? ST_IFILL : ST_DFILL;
                    end else if (i_req) begin
                        r_state_q <= ST_IFILL;
                    end else if (d_req) begin
                        r_state_q <= ST_DFILL;
                    end
                end
                ST_IFILL, ST_DFILL: begin
                    // Release is driven only by the beat count; the owner's
                    // request level is not consulted mid-fill.
                    if (mem_data_valid) begin
                        if (r_beat_q == C_LAST_BEAT) begin
                            r_beat_q   <= 4'd0;
                            r_last_d_q <= (r_state_q == ST_DFILL);
                            r_state_q  <= ST_IDLE;
                        end else begin
                            r_beat_q <= r_beat_q + 4'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_state_q <= ST_IDLE;
                end
                default: begin
                    r_state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    logic w_ifill;
    logic w_dfill;
    logic w_write;

    assign w_ifill = (r_state_q == ST_IFILL);
    assign w_dfill = (r_state_q == ST_DFILL);
    assign w_write = (r_state_q == ST_WRITE);

    assign mem_enable   = w_ifill | w_dfill | w_write;
    assign mem_wr       = w_write;
    assign mem_addr     = w_ifill ? i_addr    :
                          w_dfill ? d_addr    :
                          w_write ? d_wr_addr : '0;
    assign mem_data_in  = w_write ? d_wr_data : '0;
    assign i_grant      = w_ifill;
    assign d_grant      = w_dfill;
    assign d_wr_ack     = w_write;
    assign i_data_valid = w_ifill & mem_data_valid;
    assign d_data_valid = w_dfill & mem_data_valid;
    assign fill_data    = mem_data_out;
    assign busy         = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Table-driven check of mem_arbiter. Each record gives the
//               control inputs for one cycle and the arbiter state expected
//               during that cycle; all outputs are derived from that state.
//               A few hand-written sequences follow for latency and pulse
//               counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int BEATS  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] E_IDLE  = 2'd0;
    localparam logic [1:0] E_IFILL = 2'd1;
    localparam logic [1:0] E_DFILL = 2'd2;
    localparam logic [1:0] E_WRITE = 2'd3;

    localparam logic [ADDR_W-1:0] C_WADDR = 16'h2002;
    localparam logic [DATA_W-1:0] C_WDATA = 16'hBEEF;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_data_valid;
    logic              mem_enable;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              i_grant;
    logic              d_grant;
    logic              d_wr_ack;
    logic              i_data_valid;
    logic              d_data_valid;
    logic [DATA_W-1:0] fill_data;
    logic              busy;

    mem_arbiter #(
        .BEATS (BEATS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .d_req         (d_req),
        .d_addr        (d_addr),
        .d_wr_req      (d_wr_req),
        .d_wr_addr     (d_wr_addr),
        .d_wr_data     (d_wr_data),
        .mem_data_out  (mem_data_out),
        .mem_data_valid(mem_data_valid),
        .mem_enable    (mem_enable),
        .mem_wr        (mem_wr),
        .mem_addr      (mem_addr),
        .mem_data_in   (mem_data_in),
        .i_grant       (i_grant),
        .d_grant       (d_grant),
        .d_wr_ack      (d_wr_ack),
        .i_data_valid  (i_data_valid),
        .d_data_valid  (d_data_valid),
        .fill_data     (fill_data),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ir;
        logic       dr;
        logic       wr;
        logic       mv;
        logic [1:0] st;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic ir, input logic dr,
                       input logic wr, input logic mv, input logic [1:0] st);
        vec_t v;
        v.rst = r; v.ir = ir; v.dr = dr; v.wr = wr; v.mv = mv; v.st = st;
        vq.push_back(v);
    endtask

    task automatic addn(input int n, input logic r, input logic ir,
                        input logic dr, input logic wr, input logic mv,
                        input logic [1:0] st);
        for (int j = 0; j < n; j++) add(r, ir, dr, wr, mv, st);
    endtask

    // Compare every output against what the given state implies.
    task automatic check_state(input logic [1:0] st, input string name);
        logic              e_en, e_wr, e_ig, e_dg, e_ack, e_idv, e_ddv, e_busy;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_din;
        e_en   = (st != E_IDLE);
        e_wr   = (st == E_WRITE);
        e_ig   = (st == E_IFILL);
        e_dg   = (st == E_DFILL);
        e_ack  = (st == E_WRITE);
        e_idv  = (st == E_IFILL) && mem_data_valid;
        e_ddv  = (st == E_DFILL) && mem_data_valid;
        e_busy = (st != E_IDLE);
        e_addr = (st == E_IFILL) ? i_addr :
                 (st == E_DFILL) ? d_addr :
                 (st == E_WRITE) ? C_WADDR : '0;
        e_din  = (st == E_WRITE) ? C_WDATA : '0;
        n_vec++;
        if ({mem_enable, mem_wr, i_grant, d_grant, d_wr_ack, i_data_valid,
             d_data_valid, busy, mem_addr, mem_data_in, fill_data} !==
            {e_en, e_wr, e_ig, e_dg, e_ack, e_idv, e_ddv, e_busy,
             e_addr, e_din, mem_data_out}) begin
            n_bad++;
            $display("FAIL %s: got en=%b wr=%b ig=%b dg=%b ack=%b idv=%b ddv=%b busy=%b addr=%h din=%h fd=%h, want en=%b wr=%b ig=%b dg=%b ack=%b idv=%b ddv=%b busy=%b addr=%h din=%h fd=%h",
                     name, mem_enable, mem_wr, i_grant, d_grant, d_wr_ack,
                     i_data_valid, d_data_valid, busy, mem_addr, mem_data_in,
                     fill_data, e_en, e_wr, e_ig, e_dg, e_ack, e_idv, e_ddv,
                     e_busy, e_addr, e_din, mem_data_out);
        end
    endtask

    task automatic check_int(input int got, input int want, input string name);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int acks;
        logic ok;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        mem_data_valid = 1'b0;
        i_addr = 16'h1000; d_addr = 16'h3000;
        d_wr_addr = C_WADDR; d_wr_data = C_WDATA; mem_data_out = 16'h0;
        repeat (2) @(posedge clk);

        // ---- reset state ----
        add(1, 0, 0, 0, 0, E_IDLE);
        // ---- single I fill, valids spaced 4 cycles; req dropped after grant
        add(0, 1, 0, 0, 0, E_IDLE);
        for (int b = 0; b < BEATS; b++) begin
            addn(3, 0, 0, 0, 0, 0, E_IFILL);
            add(0, 0, 0, 0, 1, E_IFILL);
        end
        add(0, 0, 0, 0, 0, E_IDLE);
        // ---- reset, stray valid in IDLE, then contested fills alternate
        add(1, 0, 0, 0, 0, E_IDLE);
        add(0, 0, 0, 0, 1, E_IDLE);
        add(0, 1, 1, 0, 0, E_IDLE);
        add(0, 0, 1, 0, 0, E_IFILL);          // first fill cycle, no valid
        addn(BEATS, 0, 0, 1, 0, 1, E_IFILL);
        add(0, 0, 1, 0, 0, E_IDLE);
        addn(BEATS, 0, 0, 0, 0, 1, E_DFILL);
        add(0, 1, 1, 0, 0, E_IDLE);
        addn(BEATS, 0, 0, 0, 0, 1, E_IFILL);
        // ---- write beats both pending fills
        add(0, 1, 1, 1, 0, E_IDLE);
        add(0, 1, 1, 0, 0, E_WRITE);
        add(0, 1, 1, 0, 0, E_IDLE);
        addn(BEATS, 0, 1, 0, 0, 1, E_DFILL);
        add(0, 1, 0, 0, 0, E_IDLE);
        addn(BEATS, 0, 0, 0, 0, 1, E_IFILL);
        // ---- write raised on 3rd beat of a D fill waits for the fill
        add(0, 0, 1, 0, 0, E_IDLE);
        addn(2, 0, 0, 0, 0, 1, E_DFILL);
        addn(BEATS - 2, 0, 1, 0, 1, 1, E_DFILL);
        add(0, 1, 0, 1, 0, E_IDLE);
        add(0, 1, 0, 0, 0, E_WRITE);
        add(0, 1, 0, 0, 0, E_IDLE);
        // ---- reset after 5 beats of an I fill discards the count
        addn(5, 0, 0, 0, 0, 1, E_IFILL);
        add(1, 0, 0, 0, 0, E_IFILL);
        add(0, 0, 0, 0, 1, E_IDLE);
        add(0, 1, 0, 0, 0, E_IDLE);
        addn(BEATS - 1, 0, 0, 0, 0, 1, E_IFILL);
        add(0, 0, 0, 0, 0, E_IFILL);
        add(0, 0, 0, 0, 1, E_IFILL);
        add(0, 0, 0, 0, 0, E_IDLE);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            rst            = vq[k].rst;
            i_req          = vq[k].ir;
            d_req          = vq[k].dr;
            d_wr_req       = vq[k].wr;
            mem_data_valid = vq[k].mv;
            i_addr         = 16'h1000 + 16'(k);
            d_addr         = 16'h3000 + 16'(k);
            mem_data_out   = 16'hA000 ^ 16'(k * 7);
            #1;
            check_state(vq[k].st, $sformatf("vec%0d", k));
        end

        // ---- hand sequence: grant latency, beat pulses, release ----
        @(negedge clk);
        rst = 1'b0; d_req = 1'b0; d_wr_req = 1'b0; mem_data_valid = 1'b0;
        i_req = 1'b1;
        lat = 0; ok = 1'b0;
        for (int c = 1; c <= 10 && !ok; c++) begin
            @(negedge clk); #1;
            if (i_grant) begin
                ok = 1'b1;
                lat = c;
            end
        end
        check_int(lat, 1, "grant_latency");
        i_req = 1'b0;
        pulses = 0;
        for (int b = 0; b < BEATS; b++) begin
            mem_data_valid = 1'b1;
            #1;
            if (i_data_valid) pulses++;
            if (d_data_valid) pulses += 100;
            @(negedge clk);
        end
        mem_data_valid = 1'b0;
        #1;
        check_int(pulses, BEATS, "i_valid_pulses");
        check_int(int'(busy), 0, "busy_after_fill");

        // ---- hand sequence: write acknowledged exactly once ----
        @(negedge clk);
        d_wr_req = 1'b1;
        acks = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (d_wr_ack) begin
                acks++;
                d_wr_req = 1'b0;
            end
        end
        check_int(acks, 1, "write_ack_count");
        check_int(int'(mem_enable), 0, "idle_after_write");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
